rom_load_ctrl: RTL and testbench

//  Sequences the HPS ioctl ROM download into the core's CPU-ROM and speech-ROM regions.

---
 rtl/berzerk_pkg.sv | 32 +++
 rtl/rom_load_ctrl_if.sv | 53 +++++
 rtl/rom_region_dec.sv | 44 ++++
 rtl/rom_load_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_rom_load_ctrl.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/berzerk_pkg.sv
// Package: berzerk_pkg
// Shared types and default sizes for the Berzerk ROM download path.
//   ld_state_t  : loader FSM states (hold / run / load)
//   rgn_sel_t   : region an image byte offset decodes to
//   ROM_TOTAL   : default full image size (CPU + speech regions)
//   sat_inc17   : saturating increment for the 17-bit byte counter
// Optional feature macro used by the files that import this package: ROM_CKSUM_EN.
package berzerk_pkg;

    localparam logic [15:0] CPU_SIZE_DEF    = 16'h4000;
    localparam logic [15:0] SND_SIZE_DEF    = 16'h1000;
    localparam logic [16:0] ROM_TOTAL       = 17'(CPU_SIZE_DEF) + 17'(SND_SIZE_DEF);
    localparam int          HOLD_CYCLES_DEF = 1024;
    localparam logic [15:0] CKSUM_EXP_DEF   = 16'h0000;

    typedef enum logic [1:0] {
        LD_HOLD,
        LD_RUN,
        LD_LOAD
    } ld_state_t;

    typedef enum logic [1:0] {
        RGN_CPU,
        RGN_SND,
        RGN_OVER
    } rgn_sel_t;

    function automatic logic [16:0] sat_inc17(input logic [16:0] v);
        return (v == 17'h1FFFF) ? v : v + 17'd1;
    endfunction

endpackage

// File: rtl/rom_load_ctrl_if.sv
// Interface: rom_load_ctrl_if
// Bundles the hps_io ioctl download bus, the region write port towards the
// core ROMs and the loader status flags.
//   ioctl_download/ioctl_wr/ioctl_addr/ioctl_dout : from hps_io
//   dn_addr/dn_data/dn_wr_cpu/dn_wr_snd           : region-local ROM write
//   core_reset                                    : reset to the berzerk core
//   load_done/err_short/err_over/byte_cnt         : download status
//   cksum_ok                                      : only with ROM_CKSUM_EN
// Modports: slave = the loader, master = the hps_io / core side.
interface rom_load_ctrl_if;

    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr_cpu;
    logic        dn_wr_snd;
    logic        core_reset;
    logic        load_done;
    logic        err_short;
    logic        err_over;
    logic [16:0] byte_cnt;
`ifdef ROM_CKSUM_EN
    logic        cksum_ok;

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        output dn_addr, dn_data, dn_wr_cpu, dn_wr_snd, core_reset,
        output load_done, err_short, err_over, byte_cnt, cksum_ok
    );

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        input  dn_addr, dn_data, dn_wr_cpu, dn_wr_snd, core_reset,
        input  load_done, err_short, err_over, byte_cnt, cksum_ok
    );
`else
    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        output dn_addr, dn_data, dn_wr_cpu, dn_wr_snd, core_reset,
        output load_done, err_short, err_over, byte_cnt
    );

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        input  dn_addr, dn_data, dn_wr_cpu, dn_wr_snd, core_reset,
        input  load_done, err_short, err_over, byte_cnt
    );
`endif

endinterface

// File: rtl/rom_region_dec.sv
// Module: rom_region_dec
// Combinational decode of an image byte offset into the CPU-ROM region,
// the speech-ROM region or out of range, plus the region-local address.
// Ports:
//   addr       in   25  image byte offset
//   sel_cpu    out  1   offset falls in the CPU ROM region
//   sel_snd    out  1   offset falls in the speech ROM region
//   over       out  1   offset is beyond the end of the image
//   local_addr out  16  offset relative to the start of its region
module rom_region_dec
    import berzerk_pkg::*;
#(
    parameter logic [15:0] CPU_SIZE = CPU_SIZE_DEF,
    parameter logic [15:0] SND_SIZE = SND_SIZE_DEF
) (
    input  logic [24:0] addr,
    output logic        sel_cpu,
    output logic        sel_snd,
    output logic        over,
    output logic [15:0] local_addr
);

    localparam logic [24:0] CPU_END = 25'(CPU_SIZE);
    localparam logic [24:0] IMG_END = 25'(CPU_SIZE) + 25'(SND_SIZE);

    rgn_sel_t rgn;

    always_comb begin
        rgn = RGN_OVER;
        if (addr < CPU_END) begin
            rgn = RGN_CPU;
        end else if (addr < IMG_END) begin
            rgn = RGN_SND;
        end
    end

    assign sel_cpu = (rgn == RGN_CPU);
    assign sel_snd = (rgn == RGN_SND);
    assign over    = (rgn == RGN_OVER);

    // A speech offset is below SND_SIZE, so the low-16-bit subtraction is exact.
    assign local_addr = addr[15:0] - (sel_snd ? CPU_SIZE : 16'h0000);

endmodule

// File: rtl/rom_load_ctrl.sv
// Module: rom_load_ctrl
// Sequences the hps_io ioctl ROM download into the CPU-ROM and speech-ROM
// regions of the berzerk core, retiming each in-range byte as a region-local
// write strobe, and holds the core in reset during the load and for
// HOLD_CYCLES clocks after it (and after reset).
// Ports:
//   clk_sys  in  1  system clock
//   reset    in  1  synchronous, active-high
//   bus      slave modport of rom_load_ctrl_if (ioctl in, dn_* / status out)
// Optional feature: define ROM_CKSUM_EN to add a 16-bit byte-sum check of the
// image (bus.cksum_ok); load_done then also requires a matching sum.
//
// state   | meaning
// --------+-----------------------------------------------------------
// LD_HOLD | core held in reset, hold_cnt counting down to release
// LD_RUN  | core running, waiting for a new download
// LD_LOAD | download window open, bytes forwarded to the ROM regions
module rom_load_ctrl
    import berzerk_pkg::*;
#(
    parameter logic [15:0] CPU_SIZE    = CPU_SIZE_DEF,
    parameter logic [15:0] SND_SIZE    = SND_SIZE_DEF,
    parameter int          HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter logic [15:0] CKSUM_EXP   = CKSUM_EXP_DEF
) (
    input  logic             clk_sys,
    input  logic             reset,
    rom_load_ctrl_if.slave   bus
);

    localparam int          HW          = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_CYCLES - 1);
    localparam logic [16:0] IMG_TOTAL   = 17'(CPU_SIZE) + 17'(SND_SIZE);

    ld_state_t     state, state_nxt;
    logic [HW-1:0] hold_cnt, hold_cnt_nxt;

    logic          dec_cpu, dec_snd, dec_over;
    logic [15:0]   dec_addr;

    logic [15:0]   dn_addr_q;
    logic [7:0]    dn_data_q;
    logic          dn_wr_cpu_q, dn_wr_snd_q, core_reset_q;
    logic          load_done_q, err_short_q, err_over_q;
    logic [16:0]   byte_cnt_q;

    logic          in_load, wr_acc, wr_over, load_entry, load_exit;
    logic [16:0]   byte_cnt_upd;
    logic          err_over_upd, err_short_upd, ck_pass;

    rom_region_dec #(
        .CPU_SIZE (CPU_SIZE),
        .SND_SIZE (SND_SIZE)
    ) u_dec (
        .addr       (bus.ioctl_addr),
        .sel_cpu    (dec_cpu),
        .sel_snd    (dec_snd),
        .over       (dec_over),
        .local_addr (dec_addr)
    );

    assign in_load    = (state == LD_LOAD);
    assign wr_acc     = in_load && bus.ioctl_wr && !dec_over;
    assign wr_over    = in_load && bus.ioctl_wr && dec_over;
    assign load_entry = !in_load && (state_nxt == LD_LOAD);
    assign load_exit  = in_load && !bus.ioctl_download;

    // A byte strobed on the same cycle the window closes is folded in
    // before the end-of-load flags are evaluated.
    assign byte_cnt_upd  = wr_acc ? sat_inc17(byte_cnt_q) : byte_cnt_q;
    assign err_over_upd  = err_over_q | wr_over;
    assign err_short_upd = (byte_cnt_upd != IMG_TOTAL);

`ifdef ROM_CKSUM_EN
    logic [15:0] cksum_q, cksum_upd;
    logic        cksum_ok_q;

    assign cksum_upd = wr_acc ? cksum_q + {8'h00, bus.ioctl_dout} : cksum_q;
    assign ck_pass   = (cksum_upd == CKSUM_EXP);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cksum_q    <= '0;
            cksum_ok_q <= 1'b0;
        end else if (load_entry) begin
            cksum_q    <= '0;
            cksum_ok_q <= 1'b0;
        end else if (in_load) begin
            cksum_q <= cksum_upd;
            if (load_exit) begin
                cksum_ok_q <= ck_pass;
            end
        end
    end

    assign bus.cksum_ok = cksum_ok_q;
`else
    assign ck_pass = 1'b1;
`endif

    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        case (state)
            LD_HOLD: begin
                if (bus.ioctl_download) begin
                    state_nxt = LD_LOAD;
                end else if (hold_cnt == '0) begin
                    state_nxt = LD_RUN;
                end else begin
                    hold_cnt_nxt = hold_cnt - 1'b1;
                end
            end
            LD_RUN: begin
                if (bus.ioctl_download) begin
                    state_nxt = LD_LOAD;
                end
            end
            LD_LOAD: begin
                if (!bus.ioctl_download) begin
                    state_nxt    = LD_HOLD;
                    hold_cnt_nxt = HOLD_RELOAD;
                end
            end
            default: begin
                state_nxt    = LD_HOLD;
                hold_cnt_nxt = HOLD_RELOAD;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state    <= LD_HOLD;
            hold_cnt <= HOLD_RELOAD;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dn_addr_q    <= '0;
            dn_data_q    <= '0;
            dn_wr_cpu_q  <= 1'b0;
            dn_wr_snd_q  <= 1'b0;
            core_reset_q <= 1'b1;
            load_done_q  <= 1'b0;
            err_short_q  <= 1'b0;
            err_over_q   <= 1'b0;
            byte_cnt_q   <= '0;
        end else begin
            dn_wr_cpu_q  <= wr_acc && dec_cpu;
            dn_wr_snd_q  <= wr_acc && dec_snd;
            // Registered from the next state so it lines up with the FSM.
            core_reset_q <= (state_nxt != LD_RUN);
            if (wr_acc) begin
                dn_addr_q <= dec_addr;
                dn_data_q <= bus.ioctl_dout;
            end
            if (load_entry) begin
                load_done_q <= 1'b0;
                err_short_q <= 1'b0;
                err_over_q  <= 1'b0;
                byte_cnt_q  <= '0;
            end else if (in_load) begin
                byte_cnt_q <= byte_cnt_upd;
                err_over_q <= err_over_upd;
                if (load_exit) begin
                    err_short_q <= err_short_upd;
                    load_done_q <= !err_short_upd && !err_over_upd && ck_pass;
                end
            end
        end
    end

    assign bus.dn_addr    = dn_addr_q;
    assign bus.dn_data    = dn_data_q;
    assign bus.dn_wr_cpu  = dn_wr_cpu_q;
    assign bus.dn_wr_snd  = dn_wr_snd_q;
    assign bus.core_reset = core_reset_q;
    assign bus.load_done  = load_done_q;
    assign bus.err_short  = err_short_q;
    assign bus.err_over   = err_over_q;
    assign bus.byte_cnt   = byte_cnt_q;

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Testbench: tb_rom_load_ctrl
// Drives ioctl downloads into rom_load_ctrl and compares every output on
// every cycle against a behavioural model of the loader rules, plus literal
// expectations for the directed scenarios. Works with or without ROM_CKSUM_EN.
module tb_rom_load_ctrl;
    import berzerk_pkg::*;

    localparam int          H   = 1024;
    localparam int          CPU = 16384;
    localparam int          SND = 4096;
    localparam int          TOT = CPU + SND;
    localparam logic [15:0] EXP = 16'hBEEF;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;

    rom_load_ctrl_if bus ();

    rom_load_ctrl #(
        .CPU_SIZE    (16'h4000),
        .SND_SIZE    (16'h1000),
        .HOLD_CYCLES (H),
        .CKSUM_EXP   (EXP)
    ) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;
    int n_cpu  = 0;
    int n_snd  = 0;

    logic [15:0] m_addr = '0;
    logic [7:0]  m_data = '0;
    bit          m_wcpu, m_wsnd, m_core, m_done, m_short, m_over, m_ck;
    int          m_cnt = 0;
    logic [15:0] m_sum = '0;

    logic [7:0] img [TOT];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the window is open on a cycle iff download was seen
    // high (without reset) on the previous edge; core_reset is released only
    // after H reset-free and H+1 download-free edges.
    initial begin : model
        bit pd = 1'b0, pr = 1'b1, inl, r, d, w;
        int a, s_rst = 0, s_dl = 1000000;
        logic [7:0] v;
        forever begin
            @(posedge clk_sys);
            r = reset; d = bus.ioctl_download; w = bus.ioctl_wr;
            a = int'(bus.ioctl_addr); v = bus.ioctl_dout;
            inl = pd && !pr;
            m_wcpu = 1'b0; m_wsnd = 1'b0;
            if (r) begin
                m_addr = '0; m_data = '0; m_cnt = 0; m_sum = '0;
                m_done = 1'b0; m_short = 1'b0; m_over = 1'b0; m_ck = 1'b0;
            end else begin
                if (d && !inl) begin
                    m_cnt = 0; m_sum = '0;
                    m_done = 1'b0; m_short = 1'b0; m_over = 1'b0; m_ck = 1'b0;
                end
                if (inl && w) begin
                    if (a < TOT) begin
                        if (a < CPU) begin
                            m_wcpu = 1'b1; m_addr = 16'(a);
                        end else begin
                            m_wsnd = 1'b1; m_addr = 16'(a - CPU);
                        end
                        m_data = v;
                        if (m_cnt < 'h1FFFF) m_cnt++;
                        m_sum = m_sum + 16'(v);
                    end else begin
                        m_over = 1'b1;
                    end
                end
                if (inl && !d) begin
                    m_short = (m_cnt != TOT);
                    m_ck    = (m_sum == EXP);
`ifdef ROM_CKSUM_EN
                    m_done  = !m_short && !m_over && m_ck;
`else
                    m_done  = !m_short && !m_over;
`endif
                end
            end
            s_rst  = r ? 0 : ((s_rst < 1000000) ? s_rst + 1 : s_rst);
            s_dl   = (d && !r) ? 0 : ((s_dl < 1000000) ? s_dl + 1 : s_dl);
            m_core = !(s_rst >= H && s_dl >= H + 1);
            pd = d; pr = r;
            #1;
            check("dn_wr_cpu",  int'(bus.dn_wr_cpu),  int'(m_wcpu));
            check("dn_wr_snd",  int'(bus.dn_wr_snd),  int'(m_wsnd));
            check("dn_addr",    int'(bus.dn_addr),    int'(m_addr));
            check("dn_data",    int'(bus.dn_data),    int'(m_data));
            check("core_reset", int'(bus.core_reset), int'(m_core));
            check("load_done",  int'(bus.load_done),  int'(m_done));
            check("err_short",  int'(bus.err_short),  int'(m_short));
            check("err_over",   int'(bus.err_over),   int'(m_over));
            check("byte_cnt",   int'(bus.byte_cnt),   m_cnt);
`ifdef ROM_CKSUM_EN
            check("cksum_ok",   int'(bus.cksum_ok),   int'(m_ck));
`endif
            if (bus.dn_wr_cpu) n_cpu++;
            if (bus.dn_wr_snd) n_snd++;
        end
    end

    task automatic wr_byte(input int a, input logic [7:0] v, input int gap);
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = 25'(a);
        bus.ioctl_dout = v;
        @(negedge clk_sys);
        bus.ioctl_wr = 1'b0;
        repeat (gap) @(negedge clk_sys);
    endtask

    task automatic dl_start();
        bus.ioctl_download = 1'b1;
        @(negedge clk_sys);
    endtask

    task automatic dl_end();
        bus.ioctl_download = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic count_hold(output int n);
        n = 0;
        while (bus.core_reset && n < 5000) begin
            n++;
            @(negedge clk_sys);
        end
    endtask

    task automatic full_load(input bit paced);
        dl_start();
        n_cpu = 0; n_snd = 0;
        for (int i = 0; i < TOT; i++) begin
            if (!paced)      wr_byte(i, img[i], 0);
            else if (i < 256) wr_byte(i, img[i], 3);
            else wr_byte(i, img[i], ($urandom_range(7) == 0) ? $urandom_range(3, 1) : 0);
        end
        dl_end();
    endtask

    initial begin : stim
        int n, s, need;
        bus.ioctl_download = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = '0;

        repeat (3) @(negedge clk_sys);
        check("rst_core_reset", int'(bus.core_reset), 1);
        check("rst_byte_cnt",   int'(bus.byte_cnt),   0);
        check("rst_dn_addr",    int'(bus.dn_addr),    0);
        check("rst_load_done",  int'(bus.load_done),  0);

        // Power-on hold with no download.
        reset = 1'b0;
        count_hold(n);
        check("por_hold_len", n, H);
        repeat (20) @(negedge clk_sys);
        check("por_no_strobe", n_cpu + n_snd, 0);

        // Single speech byte, then an over-range byte.
        dl_start();
        bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'h4000; bus.ioctl_dout = 8'hA5;
        @(negedge clk_sys);
        bus.ioctl_wr = 1'b0;
        check("snd0_strobe", int'(bus.dn_wr_snd), 1);
        check("snd0_addr",   int'(bus.dn_addr),   0);
        check("snd0_data",   int'(bus.dn_data),   'hA5);
        wr_byte('h5000, 8'h3C, 0);
        check("over_no_cpu", int'(bus.dn_wr_cpu), 0);
        check("over_no_snd", int'(bus.dn_wr_snd), 0);
        check("over_flag",   int'(bus.err_over),  1);
        check("over_hold",   int'(bus.dn_addr),   0);
        dl_end();
        check("over_done", int'(bus.load_done), 0);
        check("over_cnt",  int'(bus.byte_cnt),  1);

        // Short download, restarted while still in the post-load hold.
        repeat (30) @(negedge clk_sys);
        dl_start();
        check("restart_clears_over", int'(bus.err_over), 0);
        for (int i = 0; i < 100; i++) wr_byte($urandom_range(TOT - 1), 8'($urandom), $urandom_range(2));
        dl_end();
        check("short_flag", int'(bus.err_short), 1);
        check("short_done", int'(bus.load_done), 0);
        check("short_cnt",  int'(bus.byte_cnt),  100);

        // Back-to-back strobes, last one on the cycle the window closes.
        dl_start();
        n_cpu = 0; n_snd = 0;
        for (int i = 0; i < 19; i++) wr_byte($urandom_range(TOT - 1), 8'($urandom), 0);
        bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'h4FFF; bus.ioctl_dout = 8'h81;
        bus.ioctl_download = 1'b0;
        @(negedge clk_sys);
        bus.ioctl_wr = 1'b0;
        check("b2b_last_snd",  int'(bus.dn_wr_snd), 1);
        check("b2b_last_addr", int'(bus.dn_addr),   'hFFF);
        check("b2b_cnt",       int'(bus.byte_cnt),  20);
        repeat (2) @(negedge clk_sys);
        check("b2b_strobes",   n_cpu + n_snd,       20);

        // Full image with a sum that matches EXP.
        s = 0;
        for (int i = 0; i < TOT - 300; i++) begin
            img[i] = 8'($urandom);
            s = s + int'(img[i]);
        end
        need = (int'(EXP) - s) & 'hFFFF;
        for (int i = TOT - 300; i < TOT; i++) begin
            img[i] = 8'((need > 255) ? 255 : need);
            need = need - int'(img[i]);
        end
        full_load(1'b1);
        check("full_cpu_strobes", n_cpu, CPU);
        check("full_snd_strobes", n_snd, SND);
        check("full_cnt",   int'(bus.byte_cnt),  TOT);
        check("full_done",  int'(bus.load_done), 1);
        check("full_short", int'(bus.err_short), 0);
`ifdef ROM_CKSUM_EN
        check("full_cksum", int'(bus.cksum_ok), 1);
`endif
        count_hold(n);
        check("full_hold_len", n, H);

`ifdef ROM_CKSUM_EN
        // Same image with one byte off by one: sum mismatched by 1.
        for (int i = 0; i < TOT; i++) begin
            if (img[i] != 8'hFF) begin
                img[i] = img[i] + 8'd1;
                break;
            end
        end
        full_load(1'b0);
        check("ck_bad_ok",    int'(bus.cksum_ok),  0);
        check("ck_bad_done",  int'(bus.load_done), 0);
        check("ck_bad_short", int'(bus.err_short), 0);
`endif

        // Reset mid-load with a same-cycle strobe.
        dl_start();
        wr_byte('h123, 8'h77, 1);
        bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'h0010; bus.ioctl_dout = 8'h55;
        reset = 1'b1;
        @(negedge clk_sys);
        bus.ioctl_wr = 1'b0; bus.ioctl_download = 1'b0;
        check("mid_rst_cpu",   int'(bus.dn_wr_cpu),  0);
        check("mid_rst_snd",   int'(bus.dn_wr_snd),  0);
        check("mid_rst_addr",  int'(bus.dn_addr),    0);
        check("mid_rst_data",  int'(bus.dn_data),    0);
        check("mid_rst_cnt",   int'(bus.byte_cnt),   0);
        check("mid_rst_core",  int'(bus.core_reset), 1);
        check("mid_rst_flags", int'({bus.load_done, bus.err_short, bus.err_over}), 0);
        reset = 1'b0;
        repeat (50) @(negedge clk_sys);

        // Random traffic, including boundary offsets and occasional resets.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(299) == 0) reset = 1'b1;
            else reset = 1'b0;
            if ($urandom_range(39) == 0) bus.ioctl_download = ~bus.ioctl_download;
            bus.ioctl_wr = 1'($urandom_range(1));
            case ($urandom_range(7))
                0:       bus.ioctl_addr = 25'h3FFF;
                1:       bus.ioctl_addr = 25'h4000;
                2:       bus.ioctl_addr = 25'h4FFF;
                3:       bus.ioctl_addr = 25'h5000;
                4:       bus.ioctl_addr = 25'($urandom);
                default: bus.ioctl_addr = 25'($urandom_range(TOT - 1));
            endcase
            bus.ioctl_dout = 8'($urandom);
            @(negedge clk_sys);
        end
        reset = 1'b0; bus.ioctl_wr = 1'b0; bus.ioctl_download = 1'b0;
        repeat (5) @(negedge clk_sys);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
